seg_scan_driver: RTL and testbench

//  Consumes the 16-bit packed BCD score word (P1 tens/ones, P2 tens/ones) and drives a
//  4-digit common-anode multiplexed 7-segment display. Sits between score merging and pins.

---
 rtl/seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg_scan_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment driver for the packed BCD score word.
// Latches the score once per frame, blanks leading zeros, adds a guard time and an optional blink.
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 64,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] disp_data,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [15:0]      r_latch;
    logic [CNT_W-1:0] r_frameCnt;
    logic             r_blinkPhase;
    logic [6:0]       r_segH;
    logic             r_dpH;
    logic [3:0]       r_anH;
    logic             r_frameDone;

    logic             w_divTerm;
    logic             w_frameEnd;
    logic [3:0]       w_nib;
    logic [6:0]       w_segDec;
    logic             w_blank;
    logic             w_guard;
    logic [3:0]       w_anH;

    assign w_divTerm  = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_frameEnd = w_divTerm && (r_idx == 2'd3);
    assign w_nib      = r_latch[{r_idx, 2'b00} +: 4];

    // Digits 3 and 1 are the tens digits of each player; only those are zero-blanked.
    assign w_blank = r_idx[0] && (w_nib == 4'd0);
    assign w_guard = (r_div < DIV_W'(GUARD));
    assign w_anH   = (w_guard || w_blank || r_blinkPhase) ? 4'b0000 : (4'b0001 << r_idx);

    always_comb begin
        w_segDec = 7'h79;
        case (w_nib)
            4'd0:    w_segDec = 7'h3F;
            4'd1:    w_segDec = 7'h06;
            4'd2:    w_segDec = 7'h5B;
            4'd3:    w_segDec = 7'h4F;
            4'd4:    w_segDec = 7'h66;
            4'd5:    w_segDec = 7'h6D;
            4'd6:    w_segDec = 7'h7D;
            4'd7:    w_segDec = 7'h07;
            4'd8:    w_segDec = 7'h7F;
            4'd9:    w_segDec = 7'h6F;
            default: w_segDec = 7'h79;
        endcase
    end

    // The score is only sampled on the digit 3 -> 0 wrap so a frame never mixes two scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= 2'd0;
            r_latch <= 16'h0000;
        end else if (w_divTerm) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_latch <= disp_data;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (!blink_en) begin
            r_frameCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (w_frameEnd) begin
            if (r_frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frameCnt   <= '0;
                r_blinkPhase <= ~r_blinkPhase;
            end else begin
                r_frameCnt <= r_frameCnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segH      <= 7'h00;
            r_dpH       <= 1'b0;
            r_anH       <= 4'h0;
            r_frameDone <= 1'b0;
        end else begin
            r_segH      <= w_segDec;
            r_dpH       <= (r_idx == 2'd2);
            r_anH       <= w_anH;
            r_frameDone <= w_frameEnd;
        end
    end

    assign seg        = (SEG_ACT_LOW != 0) ? ~r_segH : r_segH;
    assign dp         = (SEG_ACT_LOW != 0) ? ~r_dpH  : r_dpH;
    assign an         = (DIG_ACT_LOW != 0) ? ~r_anH  : r_anH;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-count reference model predicts every pin value,
// a negedge monitor pops and compares.
module tb_seg_scan_driver;

    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;
    localparam logic [12:0] INACTIVE = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic        clk;
    logic        rst_n;
    logic [15:0] disp_data;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks;
    int passes;

    logic [12:0] sb[$];
    logic [6:0]  segTable[16];

    int          k;
    int          nBlink;
    logic [15:0] mLatch;

    seg_scan_driver #(
        .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .blink_en(blink_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    end

    // Reference model: after k clocks since reset release, the scan sits in slot (k/SD)%4 at
    // offset k%SD. The pins after the next edge show that state.
    always @(posedge clk) begin
        int          slot;
        int          offs;
        logic [3:0]  nib;
        logic        lit;
        logic        boundary;
        logic [3:0]  anOn;
        if (!rst_n) begin
            k      = 0;
            nBlink = 0;
            mLatch = 16'h0000;
            sb.push_back(INACTIVE);
        end else begin
            slot     = (k / SD) % 4;
            offs     = k % SD;
            nib      = 4'((mLatch >> (4 * slot)) & 16'hF);
            boundary = ((k % FRAME) == FRAME - 1);
            lit      = (offs >= GD)
                       && !(((slot == 3) || (slot == 1)) && (nib == 4'd0))
                       && (((nBlink / BF) % 2) == 0);
            anOn     = lit ? 4'(1 << slot) : 4'h0;
            sb.push_back({~anOn, ~segTable[nib], ~(slot == 2), boundary});
            if (!blink_en) nBlink = 0;
            else if (boundary) nBlink = nBlink + 1;
            if (boundary) mLatch = disp_data;
            k = k + 1;
        end
    end

    task automatic checkOutput(input logic [12:0] e);
        logic [12:0] a;
        a = {an, seg, dp, frame_done};
        checks++;
        if (a !== e) begin
            $display("[TB] FAIL pins t=%0t actual an=%h seg=%h dp=%b fd=%b required an=%h seg=%h dp=%b fd=%b",
                     $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
        end else begin
            passes++;
        end
    endtask

    // Monitor: reset must drive the pins inactive immediately, overriding any queued prediction.
    always @(negedge clk) begin
        logic [12:0] e;
        if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_empty t=%0t actual size=0 required size>0", $time);
        end else begin
            e = sb.pop_front();
            if (!rst_n) e = INACTIVE;
            checkOutput(e);
        end
    end

    task automatic applyStimulus(input logic [15:0] data, input logic blink, input int cycles);
        disp_data = data;
        blink_en  = blink;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic pulseReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        disp_data = 16'h0000;
        blink_en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        applyStimulus(16'h1107, 1'b0, 2 * FRAME + 6);
        applyStimulus(16'h0305, 1'b0, FRAME + 10);
        applyStimulus(16'h0906, 1'b0, 2 * FRAME);
        applyStimulus(16'h000C, 1'b0, FRAME + 4);
        applyStimulus(16'h4291, 1'b1, 5 * FRAME + 3);
        applyStimulus(16'h4291, 1'b0, FRAME);
        pulseReset(2);
        applyStimulus(16'h5678, 1'b0, 19);
        pulseReset(1);
        applyStimulus(16'h5678, 1'b0, 2 * FRAME);

        for (int i = 0; i < 200; i++) begin
            d = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 11)), 4'($urandom_range(0, 10))};
            if ($urandom_range(0, 24) == 0) pulseReset($urandom_range(1, 3));
            applyStimulus(d, ($urandom_range(0, 2) == 0), $urandom_range(1, 45));
        end

        blink_en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
